// File: rtl/decode_stage_controller_pkg.sv
// Shared stage codes broadcast by the decode controller and decoded by every PU.
package decode_stage_controller_pkg;

  localparam int unsigned STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_PEELING             = 3'd4,
    STAGE_RESULT_VALID        = 3'd5
  } stage_e;

  // Stages that wait for the array to go quiet before moving on.
  function automatic logic is_settle_stage(input stage_e s);
    return (s == STAGE_MERGE) || (s == STAGE_PEELING);
  endfunction

endpackage

// File: rtl/decode_stage_controller_settle_detector.sv
// Counts consecutive cycles with the whole PU array idle; settled_c fires on
// the cycle that completes a window of SETTLE_CYCLES idle cycles.
module decode_stage_controller_settle_detector #(
  parameter int unsigned PU_COUNT      = 16,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [PU_COUNT-1:0] busy,
  output logic                settled_c
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic             any_busy_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Array-wide busy reduction; a late glitch simply restarts the window.
  assign any_busy_c = |busy;

  assign settled_c = !any_busy_c && (cnt_q == CNT_LAST);

  // Next idle-run length: cleared on stage entry or any busy cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || any_busy_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Idle-run register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decode_stage_controller.sv
// Decode sequencer: load -> merge/grow loop until no odd cluster -> peel -> result.
// Optional build macro: DECODE_CYCLE_COUNTER_EN adds a saturating decode
// latency counter on cycle_count; otherwise cycle_count is tied to zero.
import decode_stage_controller_pkg::*;

module decode_stage_controller #(
  parameter int unsigned PU_COUNT      = 16,
  parameter int unsigned STAGE_WIDTH   = 3,
  parameter int unsigned LOAD_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned MAX_GROW      = 63,
  parameter int unsigned ITER_WIDTH    = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic [PU_COUNT-1:0]    busy,
  input  logic [PU_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [ITER_WIDTH-1:0]  grow_count,
  output logic                   timeout,
  output logic [31:0]            cycle_count
);

  localparam int unsigned LOAD_CNT_W = $clog2(LOAD_CYCLES + 1);
  localparam logic [LOAD_CNT_W-1:0] LOAD_LAST = LOAD_CNT_W'(LOAD_CYCLES - 1);
  localparam logic [ITER_WIDTH-1:0] GROW_MAX  = ITER_WIDTH'(MAX_GROW);
  localparam int unsigned CYCLE_W = 32;

  stage_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   result_valid_q, result_valid_d;
  logic [LOAD_CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [ITER_WIDTH-1:0]  grow_count_q, grow_count_d;
  logic                   timeout_q, timeout_d;
  logic                   start_accept_c;
  logic                   any_odd_c;
  logic                   settle_clear_c;
  logic                   settled_c;

  assign start_accept_c = start && ready_q;
  assign any_odd_c      = |odd;

  // Window restarts on every stage entry and stays parked outside MERGE/PEELING.
  assign settle_clear_c = (state_d != state_q) || !is_settle_stage(state_q);

  decode_stage_controller_settle_detector #(
    .PU_COUNT      (PU_COUNT),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk       (clk),
    .reset     (reset),
    .clear     (settle_clear_c),
    .busy      (busy),
    .settled_c (settled_c)
  );

  // Next-state and counter update for the stage sequencer.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    grow_count_d = grow_count_q;
    timeout_d    = timeout_q;

    case (state_q)
      STAGE_IDLE: begin
        if (start_accept_c) begin
          state_d      = STAGE_MEASUREMENT_LOADING;
          load_cnt_d   = '0;
          grow_count_d = '0;
          timeout_d    = 1'b0;
        end
      end
      STAGE_MEASUREMENT_LOADING: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d    = STAGE_MERGE;
          load_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + LOAD_CNT_W'(1);
        end
      end
      STAGE_MERGE: begin
        if (settled_c) begin
          if (!any_odd_c) begin
            state_d = STAGE_PEELING;
          end else if (grow_count_q == GROW_MAX) begin
            state_d   = STAGE_PEELING;
            timeout_d = 1'b1;
          end else begin
            state_d = STAGE_GROW;
          end
        end
      end
      STAGE_GROW: begin
        state_d = STAGE_MERGE;
        if (grow_count_q != {ITER_WIDTH{1'b1}}) begin
          grow_count_d = grow_count_q + ITER_WIDTH'(1);
        end
      end
      STAGE_PEELING: begin
        if (settled_c) begin
          state_d = STAGE_RESULT_VALID;
        end
      end
      STAGE_RESULT_VALID: begin
        if (result_ack) begin
          state_d = STAGE_IDLE;
        end
      end
      default: begin
        state_d = STAGE_IDLE;
      end
    endcase
  end

  // Handshake flags registered from the next stage so they align with global_stage.
  always_comb begin
    ready_d        = (state_d == STAGE_IDLE);
    result_valid_d = (state_d == STAGE_RESULT_VALID);
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= STAGE_IDLE;
      ready_q        <= 1'b1;
      result_valid_q <= 1'b0;
      load_cnt_q     <= '0;
      grow_count_q   <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      result_valid_q <= result_valid_d;
      load_cnt_q     <= load_cnt_d;
      grow_count_q   <= grow_count_d;
      timeout_q      <= timeout_d;
    end
  end

  assign global_stage = STAGE_WIDTH'(state_q);
  assign ready        = ready_q;
  assign result_valid = result_valid_q;
  assign grow_count   = grow_count_q;
  assign timeout      = timeout_q;

`ifdef DECODE_CYCLE_COUNTER_EN
  logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;

  // Latency counter: runs from LOADING entry up to RESULT_VALID entry, saturating.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if ((state_q == STAGE_IDLE) && start_accept_c) begin
      cycle_count_d = '0;
    end else if ((state_q == STAGE_MEASUREMENT_LOADING) || (state_q == STAGE_MERGE) ||
                 (state_q == STAGE_GROW) || (state_q == STAGE_PEELING)) begin
      if (cycle_count_q != {CYCLE_W{1'b1}}) begin
        cycle_count_d = cycle_count_q + CYCLE_W'(1);
      end
    end
  end

  // Latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = CYCLE_W'(0);
`endif

endmodule

// File: tb/tb_decode_stage_controller.sv
// Scoreboard bench for decode_stage_controller: stimulus queues expected stage
// runs and result snapshots; a negedge monitor pops and compares them.
import decode_stage_controller_pkg::*;

module tb_decode_stage_controller;

  localparam int unsigned PU_COUNT = 16;
  localparam int unsigned ITER_W   = 6;

  typedef struct {
    stage_e stage;
    int     len;     // 0 = length not checked
  } run_t;

  typedef struct {
    int grow;
    int tmo;
    int cc;
  } res_t;

  logic                clk;
  logic                reset;
  logic                start;
  logic                ready;
  logic [PU_COUNT-1:0] busy;
  logic [PU_COUNT-1:0] odd;
  logic [2:0]          global_stage;
  logic                result_valid;
  logic                result_ack;
  logic [ITER_W-1:0]   grow_count;
  logic                timeout;
  logic [31:0]         cycle_count;

  run_t run_q[$];
  res_t res_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  decode_stage_controller #(
    .PU_COUNT      (PU_COUNT),
    .STAGE_WIDTH   (3),
    .LOAD_CYCLES   (2),
    .SETTLE_CYCLES (3),
    .MAX_GROW      (4),
    .ITER_WIDTH    (ITER_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ready        (ready),
    .busy         (busy),
    .odd          (odd),
    .global_stage (global_stage),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .grow_count   (grow_count),
    .timeout      (timeout),
    .cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_cc(input int n);
`ifdef DECODE_CYCLE_COUNTER_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input stage_e s, input int len);
    run_t r;
    r.stage = s;
    r.len   = len;
    run_q.push_back(r);
  endtask

  task automatic push_res(input int g, input int t, input int c);
    res_t r;
    r.grow = g;
    r.tmo  = t;
    r.cc   = c;
    res_q.push_back(r);
  endtask

  task automatic wait_stage(input stage_e s, input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (global_stage == 3'(s)) break;
      step();
    end
    if (i == 200) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_%s: stage stuck at %0d, wanted %0d", name, global_stage, s);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_ack(input int hold);
    for (int i = 0; i < hold; i++) step();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check("ready_after_ack", int'(ready), 1);
    check("rv_after_ack", int'(result_valid), 0);
  endtask

  task automatic close_run(input stage_e s, input int len);
    run_t e;
    if (run_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL run_unexpected: got stage %0d len %0d, expected nothing", s, len);
    end else begin
      e = run_q.pop_front();
      check("run_stage", int'(s), int'(e.stage));
      if (e.len != 0) check("run_len", len, e.len);
    end
  endtask

  // Monitor: tracks stage run lengths and result snapshots at the negedge.
  initial begin : monitor
    stage_e cur;
    int     len;
    logic   rv_prev;
    int     cc_exp;
    res_t   r;
    cc_exp = 0;
    @(negedge clk);
    while (reset) @(negedge clk);
    cur     = stage_e'(global_stage);
    len     = 1;
    rv_prev = result_valid;
    forever begin
      @(negedge clk);
      if (global_stage != 3'(cur)) begin
        close_run(cur, len);
        cur = stage_e'(global_stage);
        len = 1;
      end else begin
        len++;
      end
      if (result_valid && !rv_prev) begin
        if (res_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL result_unexpected: result_valid rose with nothing queued");
        end else begin
          r = res_q.pop_front();
          check("res_stage", int'(global_stage), int'(STAGE_RESULT_VALID));
          check("res_grow_count", int'(grow_count), r.grow);
          check("res_timeout", int'(timeout), r.tmo);
          check("res_cycle_count", int'(cycle_count), r.cc);
          cc_exp = r.cc;
        end
      end else if (result_valid) begin
        check("cycle_count_frozen", int'(cycle_count), cc_exp);
      end
      rv_prev = result_valid;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus.
  initial begin : stim
    reset      = 1'b1;
    start      = 1'b0;
    busy       = '0;
    odd        = '0;
    result_ack = 1'b0;
    step();
    step();
    check("rst_stage", int'(global_stage), int'(STAGE_IDLE));
    check("rst_ready", int'(ready), 1);
    check("rst_rv", int'(result_valid), 0);
    check("rst_grow", int'(grow_count), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_cycle", int'(cycle_count), 0);
    reset = 1'b0;
    step();

    // Idle array; stray start/ack during MERGE are ignored.
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_PEELING, 3);
    push_run(STAGE_RESULT_VALID, 1);
    push_res(0, 0, exp_cc(8));
    do_start();
    check("ready_low_loading", int'(ready), 0);
    wait_stage(STAGE_MERGE, "merge_idle");
    start      = 1'b1;
    result_ack = 1'b1;
    step();
    start      = 1'b0;
    result_ack = 1'b0;
    wait_stage(STAGE_RESULT_VALID, "rv_idle");
    do_ack(0);

    // One odd round.
    step();
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_GROW, 1);
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_PEELING, 3);
    push_run(STAGE_RESULT_VALID, 1);
    push_res(1, 0, exp_cc(12));
    odd = 16'h0100;
    do_start();
    wait_stage(STAGE_GROW, "grow_once");
    odd = '0;
    wait_stage(STAGE_RESULT_VALID, "rv_odd");
    do_ack(0);

    // Busy glitch in MERGE: 0,0,1,0,0,0.
    step();
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    push_run(STAGE_MERGE, 6);
    push_run(STAGE_PEELING, 3);
    push_run(STAGE_RESULT_VALID, 1);
    push_res(0, 0, exp_cc(11));
    do_start();
    wait_stage(STAGE_MERGE, "merge_glitch");
    busy = '0;
    step();
    step();
    busy = 16'h0004;
    step();
    busy = '0;
    wait_stage(STAGE_RESULT_VALID, "rv_glitch");
    do_ack(0);

    // Timeout: odd stuck high, MAX_GROW=4; result held 3 extra cycles.
    step();
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    for (int g = 0; g < 4; g++) begin
      push_run(STAGE_MERGE, 3);
      push_run(STAGE_GROW, 1);
    end
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_PEELING, 3);
    push_run(STAGE_RESULT_VALID, 4);
    push_res(4, 1, exp_cc(24));
    odd = 16'h8001;
    do_start();
    wait_stage(STAGE_PEELING, "peel_timeout");
    check("odd_high_in_peel", int'(|odd), 1);
    wait_stage(STAGE_RESULT_VALID, "rv_timeout");
    odd = '0;
    do_ack(3);

    // Timeout flag clears on the next accepted start.
    step();
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_PEELING, 3);
    push_run(STAGE_RESULT_VALID, 1);
    push_res(0, 0, exp_cc(8));
    do_start();
    check("timeout_cleared", int'(timeout), 0);
    wait_stage(STAGE_RESULT_VALID, "rv_after_timeout");
    do_ack(0);

    // Reset during PEELING, then a clean decode.
    step();
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_PEELING, 1);
    do_start();
    wait_stage(STAGE_PEELING, "peel_reset");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_stage", int'(global_stage), int'(STAGE_IDLE));
    check("midrst_ready", int'(ready), 1);
    check("midrst_rv", int'(result_valid), 0);
    step();
    push_run(STAGE_IDLE, 0);
    push_run(STAGE_MEASUREMENT_LOADING, 2);
    push_run(STAGE_MERGE, 3);
    push_run(STAGE_PEELING, 3);
    push_run(STAGE_RESULT_VALID, 1);
    push_res(0, 0, exp_cc(8));
    do_start();
    wait_stage(STAGE_RESULT_VALID, "rv_after_reset");
    do_ack(0);

    step();
    step();
    step();
    check("runs_drained", run_q.size(), 0);
    check("results_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage_controller.md
Name: decode_stage_controller

Overview:
- Central sequencer that drives `global_stage` to every processing unit in the decoding array.
- Collects each PU's `busy` and `odd` outputs and decides when to advance from load to grow, merge and peeling.
- Closes the loop the PUs only observe: loads the syndrome, iterates grow/merge until no cluster is odd, peels, then presents the result.
- Sits between the host/measurement front end and the PU array.

Parameters:
- PU_COUNT, 16, number of processing units whose busy/odd bits are reduced.
- STAGE_WIDTH, 3, width of the stage code; must match the shared stage package.
- LOAD_CYCLES, 2, cycles that STAGE_MEASUREMENT_LOADING is held (min 1).
- SETTLE_CYCLES, 3, consecutive all-idle cycles required before leaving MERGE or PEELING (min 2; covers the PU stage register plus the registered busy).
- MAX_GROW, 63, grow-iteration ceiling before forced peeling.
- ITER_WIDTH, 6, width of the iteration counter; must satisfy 2^ITER_WIDTH > MAX_GROW.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request to decode; accepted when start && ready.
- ready  out  1  high only in IDLE.
- busy  in  PU_COUNT  per-PU busy from the array.
- odd  in  PU_COUNT  per-PU odd-cluster flag.
- global_stage  out  STAGE_WIDTH  stage broadcast to all PUs.
- result_valid  out  1  high while in RESULT_VALID.
- result_ack  in  1  host consumed result.
- grow_count  out  ITER_WIDTH  number of GROW cycles issued for this decode.
- timeout  out  1  set if MAX_GROW was reached; cleared on start accept.
- cycle_count  out  32  decode latency counter (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset values:
  - global_stage=STAGE_IDLE, ready=1, result_valid=0, grow_count=0, timeout=0, cycle_count=0.
  - All internal counters are cleared.
- Reset asserted mid-decode forces STAGE_IDLE on the next edge, whatever the current state.
- IDLE:
  - On start && ready: global_stage becomes LOADING next cycle; grow_count, timeout and cycle_count clear.
- LOADING:
  - Held exactly LOAD_CYCLES cycles, then MERGE.
  - The first merge resolves initial parity and boundary.
- MERGE:
  - A settle counter increments on each cycle with busy==0 and resets to 0 on any cycle with |busy.
  - When the counter reaches SETTLE_CYCLES, odd is sampled that same cycle:
    - |odd && grow_count<MAX_GROW → GROW.
    - |odd && grow_count==MAX_GROW → timeout=1, go to PEELING.
    - ~|odd → PEELING.
  - MERGE is never shorter than SETTLE_CYCLES cycles.
- GROW:
  - Held exactly 1 cycle; grow_count increments (saturating at its maximum), then MERGE.
  - PUs raise their growth pulse on the first GROW cycle, so back-to-back GROWs are never issued.
- PEELING:
  - Same settle rule on busy; odd is ignored.
  - On reaching SETTLE_CYCLES → RESULT_VALID.
- RESULT_VALID:
  - result_valid=1, global_stage=STAGE_RESULT_VALID.
  - On result_ack → IDLE next cycle.
  - result_ack in any other state is ignored; start outside IDLE is ignored.
- Settle counter clears on every state entry.
- busy may glitch high after having been low; this resets the window and is not an error.
- PU_COUNT=1 is legal; the reductions degenerate to a wire.

Optional Feature:
- Macro DECODE_CYCLE_COUNTER_EN.
- When defined:
  - cycle_count increments every cycle from the LOADING entry through the RESULT_VALID entry, then freezes until the next start accept.
  - It saturates at 2^32-1.
- When undefined: cycle_count is tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package holds the stage codes STAGE_IDLE, STAGE_MEASUREMENT_LOADING, STAGE_GROW, STAGE_MERGE, STAGE_PEELING, STAGE_RESULT_VALID, plus STAGE_WIDTH. These are the same codes the PUs compare against.
- Controller FSM state is encoded directly as those stage codes.
- One sub-module: settle_detector. It holds the busy OR-reduce and the consecutive-idle counter, parameterized on SETTLE_CYCLES, with a clear input and a settled output. It is instantiated once and shared by MERGE and PEELING.

Test Plan:
- Idle array: start pulse, busy=0, odd=0 → LOADING 2 cycles, MERGE 3 cycles, PEELING 3 cycles, RESULT_VALID; grow_count=0; ack returns to IDLE, ready=1.
- One odd round: odd=1 during the first MERGE settle, then 0 → exactly one 1-cycle GROW, grow_count=1, second MERGE, then PEELING.
- Busy glitch: in MERGE drive busy=0,0,1,0,0,0 → exit only after the final third zero; PEELING not entered early.
- Timeout: odd held 1 with MAX_GROW=4 → four GROWs issued, timeout=1, PEELING entered with odd still high.
- Reset mid-PEELING → global_stage=IDLE next cycle, ready=1, result_valid=0; a new start decodes normally.
- With DECODE_CYCLE_COUNTER_EN, single-odd-round case → cycle_count=12 (2 LOADING + 3 MERGE + 1 GROW + 3 MERGE + 3 PEELING) and stays frozen during RESULT_VALID; without the macro it reads 0.
